// File: rtl/pskbd_pkg.sv
// Shared constants, event type and FSM encodings for the PS/2 keyboard controller.
package pskbd_pkg;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_KOVF0 = 8'h00;
    localparam logic [7:0] PS2_KOVF1 = 8'hFF;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_OVFCNT = 2'd3;

    localparam int EVT_W = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXT    = 2'd1;
    localparam logic [1:0] ST_BRK    = 2'd2;
    localparam logic [1:0] ST_EXTBRK = 2'd3;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    function automatic logic is_kovf(input logic [7:0] c);
        return (c == PS2_KOVF0) || (c == PS2_KOVF1);
    endfunction
endpackage

// File: rtl/pskbd_fifo.sv
// Event FIFO: push/pop/flush with full/empty/count; head is visible combinationally.
// Latency 1 cycle push-to-head; a push while full without a same-cycle pop is dropped and flagged.
module pskbd_fifo
    import pskbd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  push_vld,
    input  evt_t                  push_dat,
    input  logic                  pop,
    input  logic                  flush,
    output evt_t                  head_dat,
    output logic                  empty,
    output logic                  full,
    output logic                  drop,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    evt_t                  mem_q [DEPTH];
    evt_t                  mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = count_q[DEPTH_LOG2];
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        // A pop on an empty FIFO is ignored; a full FIFO accepts a push only if it also pops.
        do_pop   = pop & ~empty & ~flush;
        do_push  = push_vld & (~full | do_pop) & ~flush;
        drop     = push_vld & full & ~do_pop & ~flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/pskbd_ctrl.sv
// PS/2 set-2 prefix decoder + event FIFO + DATA/STATUS/CTRL/OVFCNT registers, level irq.
// Latency: byte strobe at edge N -> event queued and irq high after edge N+1.
// Overflow: events pushed into a full FIFO are dropped and flagged; PSKBD_CTRL_OVFCNT_EN adds a drop counter.
module pskbd_ctrl
    import pskbd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        kbd_irq,
    input  logic [7:0]  kbd_code,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        irq
);
    logic                kbd_irq_q, byte_stb;
    logic [1:0]          state_q, state_d;
    logic                evt_vld_q, evt_vld_d;
    evt_t                evt_dat_q, evt_dat_d;
    logic                ovf_q, ovf_d, kovf_q, kovf_d, ie_q, ie_d;
    logic                kovf_set, flush, ctrl_wr, rd_status;
    evt_t                head_dat;
    logic                empty, full, drop;
    logic [DEPTH_LOG2:0] count;
    logic                wdata_unused;

    assign byte_stb     = kbd_irq & ~kbd_irq_q;
    assign ctrl_wr      = cpu_wr & (cpu_addr == REG_CTRL);
    assign flush        = ctrl_wr & cpu_wdata[1];
    assign rd_status    = cpu_rd & (cpu_addr == REG_STATUS);
    assign wdata_unused = ^cpu_wdata[15:2];
    assign irq          = ie_q & ~empty;

    always_comb begin
        state_d   = state_q;
        evt_vld_d = 1'b0;
        evt_dat_d = evt_dat_q;
        kovf_set  = 1'b0;
        if (byte_stb) begin
            if (is_kovf(kbd_code)) begin
                kovf_set = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (kbd_code == PS2_EXT)      state_d = ST_EXT;
                        else if (kbd_code == PS2_BRK) state_d = ST_BRK;
                        else begin
                            evt_vld_d = 1'b1;
                            evt_dat_d = '{brk: 1'b0, ext: 1'b0, code: kbd_code};
                        end
                    end
                    ST_EXT: begin
                        if (kbd_code == PS2_BRK)      state_d = ST_EXTBRK;
                        else if (kbd_code == PS2_EXT) state_d = ST_EXT;
                        else begin
                            evt_vld_d = 1'b1;
                            evt_dat_d = '{brk: 1'b0, ext: 1'b1, code: kbd_code};
                            state_d   = ST_IDLE;
                        end
                    end
                    default: begin
                        // Break states: a further prefix aborts the sequence without an event.
                        state_d = ST_IDLE;
                        if (kbd_code != PS2_EXT && kbd_code != PS2_BRK) begin
                            evt_vld_d = 1'b1;
                            evt_dat_d = '{brk: 1'b1, ext: (state_q == ST_EXTBRK), code: kbd_code};
                        end
                    end
                endcase
            end
        end
        if (flush) begin
            state_d   = ST_IDLE;
            evt_vld_d = 1'b0;
        end
    end

    always_comb begin
        ovf_d  = (ovf_q & ~rd_status) | drop;
        kovf_d = (kovf_q & ~rd_status) | kovf_set;
        ie_d   = ctrl_wr ? cpu_wdata[0] : ie_q;
    end

    pskbd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .cpu_clk  (cpu_clk),
        .rst_n    (rst_n),
        .push_vld (evt_vld_q),
        .push_dat (evt_dat_q),
        .pop      (cpu_rd & (cpu_addr == REG_DATA)),
        .flush    (flush),
        .head_dat (head_dat),
        .empty    (empty),
        .full     (full),
        .drop     (drop),
        .count    (count)
    );

`ifdef PSKBD_CTRL_OVFCNT_EN
    logic [7:0] ovfcnt_q, ovfcnt_d;

    // A drop on the same edge as the clearing read is still counted.
    always_comb begin
        ovfcnt_d = ovfcnt_q;
        if (cpu_rd && cpu_addr == REG_OVFCNT) ovfcnt_d = '0;
        if (drop && ovfcnt_d != 8'hFF)        ovfcnt_d = ovfcnt_d + 8'd1;
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) ovfcnt_q <= '0;
        else        ovfcnt_q <= ovfcnt_d;
    end
`endif

    always_comb begin
        cpu_rdata = '0;
        case (cpu_addr)
            REG_DATA:   if (!empty) cpu_rdata[EVT_W-1:0] = head_dat;
            REG_STATUS: begin
                cpu_rdata[15]           = empty;
                cpu_rdata[14]           = full;
                cpu_rdata[13]           = ovf_q;
                cpu_rdata[12]           = kovf_q;
                cpu_rdata[DEPTH_LOG2:0] = count;
            end
            REG_CTRL:   cpu_rdata[0] = ie_q;
`ifdef PSKBD_CTRL_OVFCNT_EN
            REG_OVFCNT: cpu_rdata[7:0] = ovfcnt_q;
`endif
            default:    cpu_rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_irq_q <= 1'b0;
            state_q   <= ST_IDLE;
            evt_vld_q <= 1'b0;
            evt_dat_q <= '0;
            ovf_q     <= 1'b0;
            kovf_q    <= 1'b0;
            ie_q      <= 1'b0;
        end else begin
            kbd_irq_q <= kbd_irq;
            state_q   <= state_d;
            evt_vld_q <= evt_vld_d;
            evt_dat_q <= evt_dat_d;
            ovf_q     <= ovf_d;
            kovf_q    <= kovf_d;
            ie_q      <= ie_d;
        end
    end
endmodule

// File: tb/tb_pskbd_ctrl.sv
// Self-checking bench for pskbd_ctrl: directed vector table, hand-written corner sequences,
// and a randomized byte/register stream checked against a queue-based reference model.
module tb_pskbd_ctrl;
    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        kbd_irq;
    logic [7:0]  kbd_code;
    logic [1:0]  cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_OVFCNT = 2'd3;

    pskbd_ctrl dut (
        .cpu_clk   (cpu_clk),
        .rst_n     (rst_n),
        .kbd_irq   (kbd_irq),
        .kbd_code  (kbd_code),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .irq       (irq)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        int             nb;
        logic [3:0][7:0] b;
        int             cnt;
        logic [15:0]    evt;
        logic           kovf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_ext, m_brk, m_ovf, m_kovf, m_ie;
    int          m_drops;

    function automatic vec_t mk(int nb, logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                                logic [7:0] a3, int cnt, logic [15:0] evt, logic kovf);
        vec_t v;
        v.nb = nb; v.b[0] = a0; v.b[1] = a1; v.b[2] = a2; v.b[3] = a3;
        v.cnt = cnt; v.evt = evt; v.kovf = kovf;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge cpu_clk); kbd_code = b; kbd_irq = 1'b1;
        @(negedge cpu_clk); kbd_irq = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
        @(negedge cpu_clk); cpu_addr = a; cpu_rd = 1'b1;
        #1 d = cpu_rdata;
        @(negedge cpu_clk); cpu_rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
        @(negedge cpu_clk); cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        @(negedge cpu_clk); cpu_wr = 1'b0;
    endtask

    task automatic prep();
        logic [15:0] d;
        wr_reg(A_CTRL, 16'h0003);
        rd_reg(A_STATUS, d);
        rd_reg(A_OVFCNT, d);
    endtask

    function automatic logic [15:0] status_word(int cnt, logic o, logic k);
        logic [15:0] s;
        s = 16'(cnt);
        s[15] = (cnt == 0);
        s[14] = (cnt == 8);
        s[13] = o;
        s[12] = k;
        return s;
    endfunction

    function automatic int exp_ovfcnt(int drops);
`ifdef PSKBD_CTRL_OVFCNT_EN
        return (drops > 255) ? 255 : drops;
`else
        return 0 * drops;
`endif
    endfunction

    // Reference model: prefixes are remembered as two flags; a break prefix followed by any
    // prefix abandons the sequence; keyboard-overrun codes abandon it and raise kovf.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h00 || b == 8'hFF) begin
            m_kovf = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
            else if (b == 8'hE0) m_ext = 1'b1;
            else m_brk = 1'b1;
        end else begin
            if (m_q.size() == 8) begin m_ovf = 1'b1; m_drops++; end
            else m_q.push_back({6'd0, m_brk, m_ext, b});
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0, 1:    return 8'hE0;
            2, 3:    return 8'hF0;
            4:       return 8'h00;
            5:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [15:0] d, e;
        rst_n = 1'b0; kbd_irq = 1'b0; kbd_code = '0;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;

        // Reset state
        repeat (2) @(negedge cpu_clk);
        cpu_addr = A_STATUS; #1 check("rst_status", cpu_rdata, 16'h8000);
        cpu_addr = A_CTRL;   #1 check("rst_ctrl", cpu_rdata, 16'h0000);
        cpu_addr = A_DATA;   #1 check("rst_data", cpu_rdata, 16'h0000);
        cpu_addr = A_OVFCNT; #1 check("rst_ovfcnt", cpu_rdata, 16'h0000);
        check("rst_irq", 16'(irq), 16'h0000);
        @(negedge cpu_clk); rst_n = 1'b1;

        // Single make code: irq timing and clear on read
        wr_reg(A_CTRL, 16'h0001);
        @(negedge cpu_clk); kbd_code = 8'h1C; kbd_irq = 1'b1;
        @(negedge cpu_clk); kbd_irq = 1'b0;
        check("t1_irq_edgeN", 16'(irq), 16'h0000);
        @(negedge cpu_clk);
        check("t1_irq_edgeN1", 16'(irq), 16'h0001);
        rd_reg(A_DATA, d);
        check("t1_data", d, 16'h001C);
        check("t1_irq_after_read", 16'(irq), 16'h0000);
        rd_reg(A_DATA, d);
        check("t1_data_empty", d, 16'h0000);

        // Directed byte-sequence table
        vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h75, 8'h00, 1, 16'h0375, 1'b0));
        vecs.push_back(mk(2, 8'hF0, 8'h1C, 8'h00, 8'h00, 1, 16'h021C, 1'b0));
        vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'hE0, 8'h00, 0, 16'h0000, 1'b0));
        vecs.push_back(mk(4, 8'hE0, 8'hF0, 8'hE0, 8'h1C, 1, 16'h001C, 1'b0));
        vecs.push_back(mk(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 16'h0000, 1'b1));
        vecs.push_back(mk(3, 8'hE0, 8'h00, 8'h1C, 8'h00, 1, 16'h001C, 1'b1));
        vecs.push_back(mk(2, 8'hE0, 8'h1C, 8'h00, 8'h00, 1, 16'h011C, 1'b0));
        vecs.push_back(mk(2, 8'hF0, 8'hE1, 8'h00, 8'h00, 1, 16'h02E1, 1'b0));
        vecs.push_back(mk(1, 8'hAA, 8'h00, 8'h00, 8'h00, 1, 16'h00AA, 1'b0));
        vecs.push_back(mk(3, 8'hE0, 8'hE0, 8'h5A, 8'h00, 1, 16'h015A, 1'b0));
        vecs.push_back(mk(3, 8'hF0, 8'hF0, 8'h1C, 8'h00, 1, 16'h001C, 1'b0));
        vecs.push_back(mk(4, 8'hE0, 8'hF0, 8'hF0, 8'hFA, 1, 16'h00FA, 1'b0));
        vecs.push_back(mk(3, 8'hF0, 8'h00, 8'hFE, 8'h00, 1, 16'h00FE, 1'b1));
        foreach (vecs[i]) begin
            prep();
            for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].b[j]);
            rd_reg(A_STATUS, d);
            check($sformatf("vec%0d_count", i), 16'(d[3:0]), 16'(vecs[i].cnt));
            check($sformatf("vec%0d_kovf", i), 16'(d[12]), 16'(vecs[i].kovf));
            if (vecs[i].cnt > 0) begin
                rd_reg(A_DATA, d);
                check($sformatf("vec%0d_evt", i), d, vecs[i].evt);
            end
        end

        // Overflow: nine makes, no reads
        prep();
        repeat (9) send_byte(8'h16);
        rd_reg(A_OVFCNT, d);
        check("t3_ovfcnt", d, 16'(exp_ovfcnt(1)));
        rd_reg(A_OVFCNT, d);
        check("t3_ovfcnt_cleared", d, 16'h0000);
        rd_reg(A_STATUS, d);
        check("t3_status", d, 16'h6008);
        rd_reg(A_STATUS, d);
        check("t3_status_ovf_cleared", d, 16'h4008);
        for (int i = 0; i < 8; i++) begin
            rd_reg(A_DATA, d);
            check($sformatf("t3_drain%0d", i), d, 16'h0016);
        end

        // Full FIFO: pop and byte strobe on the same cycle
        prep();
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        @(negedge cpu_clk); kbd_code = 8'h40; kbd_irq = 1'b1; cpu_addr = A_DATA; cpu_rd = 1'b1;
        #1 check("t5_head", cpu_rdata, 16'h0010);
        @(negedge cpu_clk); kbd_irq = 1'b0; cpu_rd = 1'b0;
        @(negedge cpu_clk);
        rd_reg(A_STATUS, d);
        check("t5_status", d, 16'h4008);
        for (int i = 0; i < 8; i++) begin
            e = (i == 7) ? 16'h0040 : 16'h0011 + 16'(i);
            rd_reg(A_DATA, d);
            check($sformatf("t5_order%0d", i), d, e);
        end

        // Flush discards a pending prefix, keeps ie
        prep();
        send_byte(8'hE0);
        wr_reg(A_CTRL, 16'h0003);
        send_byte(8'h1C);
        check("t6_irq", 16'(irq), 16'h0001);
        rd_reg(A_DATA, d);
        check("t6_data", d, 16'h001C);

        // Reset mid-prefix with an event queued
        send_byte(8'h1C);
        send_byte(8'hE0);
        @(negedge cpu_clk); rst_n = 1'b0;
        #1 check("t7_irq", 16'(irq), 16'h0000);
        cpu_addr = A_STATUS; #1 check("t7_status", cpu_rdata, 16'h8000);
        cpu_addr = A_CTRL;   #1 check("t7_ctrl", cpu_rdata, 16'h0000);
        @(negedge cpu_clk); rst_n = 1'b1;
        wr_reg(A_CTRL, 16'h0001);
        send_byte(8'h1C);
        rd_reg(A_DATA, d);
        check("t7_data_after", d, 16'h001C);

        // Randomized stream against the reference model
        prep();
        m_q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_kovf = 0; m_ie = 1; m_drops = 0;
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 15);
            if (r <= 6) begin
                b = rand_byte();
                send_byte(b);
                model_byte(b);
            end else if (r <= 10) begin
                rd_reg(A_DATA, d);
                e = (m_q.size() > 0) ? m_q.pop_front() : 16'h0000;
                check($sformatf("rnd%0d_data", n), d, e);
            end else if (r <= 12) begin
                rd_reg(A_STATUS, d);
                check($sformatf("rnd%0d_status", n), d, status_word(m_q.size(), m_ovf, m_kovf));
                m_ovf = 0; m_kovf = 0;
            end else if (r == 13) begin
                rd_reg(A_OVFCNT, d);
                check($sformatf("rnd%0d_ovfcnt", n), d, 16'(exp_ovfcnt(m_drops)));
                m_drops = 0;
            end else begin
                e = 16'($urandom_range(0, 3));
                if (e[0] == 1'b0 && $urandom_range(0, 1) == 0) e[0] = 1'b1;
                wr_reg(A_CTRL, e);
                m_ie = e[0];
                if (e[1]) begin m_q.delete(); m_ext = 0; m_brk = 0; end
                rd_reg(A_CTRL, d);
                check($sformatf("rnd%0d_ctrl", n), d, 16'(m_ie));
            end
            check($sformatf("rnd%0d_irq", n), 16'(irq), 16'(m_ie && m_q.size() > 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
